// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared GF(2^8) helpers, state typedefs and FSM encoding for
//               the sequential MixColumns engine.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [15:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]  aes_col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Coefficients never exceed 4 bits, so three chained xtimes cover every term.
  function automatic logic [7:0] gf_mul(input logic [3:0] coef, input logic [7:0] b);
    logic [7:0] x1, x2, x3;
    x1 = xtime(b);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return (coef[0] ? b  : 8'h00) ^ (coef[1] ? x1 : 8'h00) ^
           (coef[2] ? x2 : 8'h00) ^ (coef[3] ? x3 : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mix_column_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_column_word
// Description : Combinational single-column (Inv)MixColumns mixer.
//               Inverse path built only when AES_MIXCOL_INV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] mixed
);

  aes_col_t w_col;
  aes_col_t w_mixed;
  assign w_col = col;
  assign mixed = w_mixed;

`ifndef AES_MIXCOL_INV_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

  always_comb begin
    w_mixed = '0;
    for (int r = 0; r < 4; r++) begin
      w_mixed[r] = gf_mul(4'h2, w_col[2'(r)])     ^ gf_mul(4'h3, w_col[2'(r + 1)]) ^
                   w_col[2'(r + 2)]               ^ w_col[2'(r + 3)];
`ifdef AES_MIXCOL_INV_EN
      if (inv) begin
        w_mixed[r] = gf_mul(4'hE, w_col[2'(r)])     ^ gf_mul(4'hB, w_col[2'(r + 1)]) ^
                     gf_mul(4'hD, w_col[2'(r + 2)]) ^ gf_mul(4'h9, w_col[2'(r + 3)]);
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_columns_seq
// Description : Multi-cycle MixColumns engine, COLS_PER_CYCLE columns per
//               clock, valid/ready in and out. Macro: AES_MIXCOL_INV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int         K       = COLS_PER_CYCLE;
  localparam int         NGROUPS = (K > 0) ? 4 / K : 1;
  localparam logic [1:0] LAST    = 2'(NGROUPS - 1);

  generate
    if (K != 1 && K != 2 && K != 4) begin : g_bad_param
      $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  mc_state_e  state_q, state_d;
  aes_state_t work_q, work_d;
  logic [1:0] cnt_q, cnt_d;
  logic       byp_q, byp_d;
  logic       out_valid_q, out_valid_d;
  logic       w_inv;
  logic       w_accept;

`ifdef AES_MIXCOL_INV_EN
  logic inv_q, inv_d;
  assign w_inv = inv_q;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign w_inv = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_state = work_q;

  // Column-group mux into the K mixer lanes.
  logic [3:0][31:0] w_cols;
  logic [1:0]       lane_idx [K];
  logic [31:0]      lane_col [K];
  logic [31:0]      lane_mix [K];
  assign w_cols = work_q;

  generate
    for (genvar j = 0; j < K; j++) begin : g_lane
      assign lane_idx[j] = 2'(int'(cnt_q) * K + j);
      assign lane_col[j] = w_cols[lane_idx[j]];
      aes_mix_column_word u_word (
        .col   (lane_col[j]),
        .inv   (w_inv),
        .mixed (lane_mix[j])
      );
    end
  endgenerate

  always_comb begin
    logic [3:0][31:0] cols_d;
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    byp_d       = byp_q;
    out_valid_d = out_valid_q;
`ifdef AES_MIXCOL_INV_EN
    inv_d       = inv_q;
`endif
    cols_d      = work_q;
    case (state_q)
      ST_BUSY: begin
        for (int j = 0; j < K; j++) begin
          cols_d[lane_idx[j]] = byp_q ? lane_col[j] : lane_mix[j];
        end
        work_d = cols_d;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == LAST) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A retire and a new accept may share one edge, so capture overrides.
    if (w_accept) begin
      work_d      = in_state;
      byp_d       = in_bypass;
      cnt_d       = 2'd0;
      state_d     = ST_BUSY;
      out_valid_d = 1'b0;
`ifdef AES_MIXCOL_INV_EN
      inv_d       = in_inv;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      cnt_q       <= 2'd0;
      byp_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef AES_MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      byp_q       <= byp_d;
      out_valid_q <= out_valid_d;
`ifdef AES_MIXCOL_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_mix_columns_seq
// Description : Self-checking bench; three engines with K = 1, 2, 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] ist  [3];
  logic         iinv [3];
  logic         ibyp [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int KK = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      aes_mix_columns_seq #(.COLS_PER_CYCLE(KK)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[g]),
        .in_ready  (ir[g]),
        .in_state  (ist[g]),
        .in_inv    (iinv[g]),
        .in_bypass (ibyp[g]),
        .out_valid (ov[g]),
        .out_ready (ordy[g]),
        .out_state (ost[g])
      );
    end
  endgenerate

  function automatic int kof(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  // Plain shift-and-add GF(2^8) product mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv, input logic byp);
    logic [7:0]   cf [4];
    logic [7:0]   a, acc;
    logic [127:0] r;
    logic         use_inv;
`ifdef AES_MIXCOL_INV_EN
    use_inv = inv;
`else
    use_inv = 1'b0 & inv;
`endif
    if (byp) return s;
    if (use_inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else         begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          a = s[(4*c + k)*8 +: 8];
          acc ^= gmul(cf[(k - row + 4) % 4], a);
        end
        r[(4*c + row)*8 +: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [31:0] col(input logic [7:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run(input int d, input logic [127:0] s, input logic inv, input logic byp,
                     output logic [127:0] res, output int lat);
    @(negedge clk);
    ist[d] = s; iinv[d] = inv; ibyp[d] = byp; iv[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ov[d]) break;
    end
    res = ost[d];
    ordy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks += 3;
      if (ov[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d] got=%b want=0", d, ov[d]); end
      if (ir[d] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d] got=%b want=1", d, ir[d]); end
      if (ost[d] !== '0)  begin failures++; $display("FAIL reset_out_state[%0d] got=%h want=0", d, ost[d]); end
    end
  endtask

  task automatic test_vectors();
    logic [127:0] s, r, e;
    int lat;
    s = {col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'h01,8'h01,8'h01,8'h01),
         col(8'hf2,8'h0a,8'h22,8'h5c), col(8'hdb,8'h13,8'h53,8'h45)};
    e = {col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'h01,8'h01,8'h01,8'h01),
         col(8'h9f,8'hdc,8'h58,8'h9d), col(8'h8e,8'h4d,8'ha1,8'hbc)};
    run(2, s, 1'b0, 1'b0, r, lat);
    checks += 2;
    if (r !== e)  begin failures++; $display("FAIL vec_k4 got=%h want=%h", r, e); end
    if (lat != 1) begin failures++; $display("FAIL vec_k4_latency got=%0d want=1", lat); end
    s = {4{col(8'hd4,8'hd4,8'hd4,8'hd5)}};
    e = {4{col(8'hd5,8'hd5,8'hd7,8'hd6)}};
    run(0, s, 1'b0, 1'b0, r, lat);
    checks += 2;
    if (r !== e)  begin failures++; $display("FAIL vec_k1 got=%h want=%h", r, e); end
    if (lat != 4) begin failures++; $display("FAIL vec_k1_latency got=%0d want=4", lat); end
  endtask

  task automatic test_random();
    logic [127:0] s, r, e;
    logic inv, byp;
    int lat;
    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 20; n++) begin
        s = rnd128(); inv = 1'($urandom); byp = ($urandom_range(0, 3) == 0);
        run(d, s, inv, byp, r, lat);
        e = model(s, inv, byp);
        checks += 2;
        if (r !== e) begin failures++; $display("FAIL random[k=%0d] got=%h want=%h", kof(d), r, e); end
        if (lat != 4 / kof(d)) begin failures++; $display("FAIL random_latency[k=%0d] got=%0d want=%0d", kof(d), lat, 4 / kof(d)); end
      end
  endtask

  task automatic test_inverse();
    logic [127:0] s, r, r2, e;
    int lat;
    s = {col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'h01,8'h01,8'h01,8'h01),
         col(8'h9f,8'hdc,8'h58,8'h9d), col(8'h8e,8'h4d,8'ha1,8'hbc)};
`ifdef AES_MIXCOL_INV_EN
    e = {col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'h01,8'h01,8'h01,8'h01),
         col(8'hf2,8'h0a,8'h22,8'h5c), col(8'hdb,8'h13,8'h53,8'h45)};
`else
    e = model(s, 1'b0, 1'b0);
`endif
    run(2, s, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== e) begin failures++; $display("FAIL inv_vector got=%h want=%h", r, e); end
`ifdef AES_MIXCOL_INV_EN
    for (int n = 0; n < 100; n++) begin
      s = rnd128();
      run(n % 3, s, 1'b0, 1'b0, r, lat);
      run(n % 3, r, 1'b1, 1'b0, r2, lat);
      checks++;
      if (r2 !== s) begin failures++; $display("FAIL roundtrip[%0d] got=%h want=%h", n, r2, s); end
    end
`endif
  endtask

  task automatic test_bypass();
    logic [127:0] s, r;
    int lat;
    for (int d = 0; d < 3; d++) begin
      s = rnd128();
      run(d, s, 1'b1, 1'b1, r, lat);
      checks += 2;
      if (r !== s) begin failures++; $display("FAIL bypass[k=%0d] got=%h want=%h", kof(d), r, s); end
      if (lat != 4 / kof(d)) begin failures++; $display("FAIL bypass_latency[k=%0d] got=%0d want=%0d", kof(d), lat, 4 / kof(d)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s, s2, e;
    int lat;
    s = rnd128(); s2 = rnd128(); e = model(s, 1'b0, 1'b0);
    @(negedge clk);
    ist[1] = s; iinv[1] = 1'b0; ibyp[1] = 1'b0; iv[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    for (int i = 0; i < 16 && !ov[1]; i++) begin @(posedge clk); @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks += 3;
      if (ost[1] !== e) begin failures++; $display("FAIL stall_state[%0d] got=%h want=%h", i, ost[1], e); end
      if (ov[1] !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b want=1", i, ov[1]); end
      if (ir[1] !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, ir[1]); end
    end
    ordy[1] = 1'b1; iv[1] = 1'b1; ist[1] = s2;
    #1;
    checks++;
    if (ir[1] !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b want=1", ir[1]); end
    @(posedge clk);
    @(negedge clk);
    ordy[1] = 1'b0; iv[1] = 1'b0;
    checks++;
    if (ov[1] !== 1'b0) begin failures++; $display("FAIL b2b_retired got=%b want=0", ov[1]); end
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); lat++; @(negedge clk);
      if (ov[1]) break;
    end
    e = model(s2, 1'b0, 1'b0);
    checks += 2;
    if (ost[1] !== e) begin failures++; $display("FAIL b2b_second got=%h want=%h", ost[1], e); end
    if (lat != 2) begin failures++; $display("FAIL b2b_latency got=%0d want=2", lat); end
    ordy[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy[1] = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] s, r, e;
    int lat;
    @(negedge clk);
    ist[0] = rnd128(); iinv[0] = 1'b0; ibyp[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks += 2;
    if (ov[0] !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", ov[0]); end
    if (ir[0] !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", ir[0]); end
    @(negedge clk);
    rst = 1'b0;
    s = rnd128(); e = model(s, 1'b0, 1'b0);
    run(0, s, 1'b0, 1'b0, r, lat);
    checks += 2;
    if (r !== e)  begin failures++; $display("FAIL midrst_next got=%h want=%h", r, e); end
    if (lat != 4) begin failures++; $display("FAIL midrst_latency got=%0d want=4", lat); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ist[d] = '0; iinv[d] = 1'b0; ibyp[d] = 1'b0; ordy[d] = 1'b0;
    end
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_vectors();
    test_random();
    test_inverse();
    test_bypass();
    test_back_to_back();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
